schoolbook_unload: RTL

Result-drain stage directly downstream of the 571x571 schoolbook multiplier. Captures the full 1142-bit product on a load pulse and streams it out as 64-bit words over a valid/ready handshake, so a narrow bus or host interface can consume the wide multiplier result. The top word is zero-padded. The block owns its own capture register, so the multiplier may start its next operation as soon as the product is captured.

---
 rtl/schoolbook_unload.sv | 97 +++++++++
 1 files changed

// File: rtl/schoolbook_unload.sv
// schoolbook_unload: captures the 1142-bit multiplier product and drains it as
// 64-bit words over valid/ready. Define SCHOOLBOOK_UNLOAD_MSW_FIRST_EN for MSW-first order.
module schoolbook_unload #(
    parameter int W  = 1142,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  c_in,
    output logic          busy,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic [4:0]    dout_idx,
    output logic          load_drop
);

    localparam int NW = (W + DW - 1) / DW;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

`ifdef SCHOOLBOOK_UNLOAD_MSW_FIRST_EN
    localparam logic [4:0] FIRST = 5'(NW - 1);
    localparam logic [4:0] LAST  = 5'd0;
`else
    localparam logic [4:0] FIRST = 5'd0;
    localparam logic [4:0] LAST  = 5'(NW - 1);
`endif

    logic [0:0]                 state;
    logic [NW-1:0][DW-1:0]      cap_q;
    logic [NW*DW-1:0]           c_ext;
    logic [NW-1:0][DW-1:0]      c_words;
    logic [4:0]                 nidx;
    logic                       xfer;
    logic                       accept;

    // Zero-extend the product to a whole number of output words
    always_comb begin
        c_ext        = '0;
        c_ext[W-1:0] = c_in;
    end

    assign c_words = c_ext;

`ifdef SCHOOLBOOK_UNLOAD_MSW_FIRST_EN
    assign nidx = dout_idx - 5'd1;
`else
    assign nidx = dout_idx + 5'd1;
`endif

    assign xfer   = dout_valid & dout_ready;
    // A new product is taken when idle, or on the final-word transfer
    assign accept = load & ((state == IDLE) | (xfer & dout_last));

    // Capture, word sequencing and registered output generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cap_q      <= '0;
            dout       <= '0;
            dout_idx   <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            load_drop  <= 1'b0;
        end else begin
            load_drop <= load & ~accept;
            if (accept) begin
                state      <= STREAM;
                cap_q      <= c_words;
                dout       <= c_words[FIRST];
                dout_idx   <= FIRST;
                dout_valid <= 1'b1;
                dout_last  <= (FIRST == LAST);
                busy       <= 1'b1;
            end else if (xfer) begin
                if (dout_last) begin
                    state      <= IDLE;
                    dout       <= '0;
                    dout_idx   <= '0;
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                    busy       <= 1'b0;
                end else begin
                    dout      <= cap_q[nidx];
                    dout_idx  <= nidx;
                    dout_last <= (nidx == LAST);
                end
            end
        end
    end

endmodule
